// File: rtl/td4_core_if.sv
// td4_core_if: ROM/port bus between the TD4 core and its surroundings
interface td4_core_if #(parameter int W = 4, parameter int PC_W = 4);
  logic [W+3:0]   instr;
  logic [W-1:0]   regIN;
  logic           run;
  logic           resume;
  logic [PC_W-1:0] regPC;
  logic [W-1:0]   regOUT;
  logic           out_valid;
  logic           carry;
  logic           halted;
  modport master (input instr, regIN, run, resume, output regPC, regOUT, out_valid, carry, halted);
  modport slave (output instr, regIN, run, resume, input regPC, regOUT, out_valid, carry, halted);
endinterface

// File: rtl/td4_core.sv
// td4_core: TD4-style 4-bit CPU core with RUN/HALT control and async active-low clear
module td4_core #(parameter int W = 4, parameter int PC_W = 4) (
  input logic clk,
  input logic clr,
  td4_core_if.master bus
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [W-1:0] a, b, out, src, im;
  logic [PC_W-1:0] pc, pc_nx, target;
  logic [W+PC_W-1:0] im_ext;
  logic [W:0] sum;
  logic [3:0] op;
  logic c, ov, exec;
  assign op = bus.instr[W+3:W];
  assign im = bus.instr[W-1:0];
  assign exec = (state == RUN) && bus.run;
  assign im_ext = {{PC_W{1'b0}}, im};
  assign target = im_ext[PC_W-1:0];
  // 10xx reads B for bit1=0 and the bare immediate for bit1=1
  assign src = op[3] ? (op[1] ? '0 : b) : (op[1:0] == 2'b00 ? a : op[1:0] == 2'b01 ? b : op[1:0] == 2'b10 ? bus.regIN : '0);
  assign sum = {1'b0, src} + {1'b0, im};
  assign pc_nx = op == 4'b1110 ? (c ? pc + PC_W'(1) : target) : op == 4'b1111 ? target : pc + PC_W'(1);
  always_comb begin
    state_nx = state;
    if (state == HALT && bus.resume) state_nx = RUN;
    if (exec && op == 4'b1100) state_nx = HALT;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RUN;
      a <= '0;
      b <= '0;
      out <= '0;
      c <= 1'b0;
      pc <= '0;
      ov <= 1'b0;
    end else begin
      state <= state_nx;
      ov <= exec && op[3:2] == 2'b10;
      if (exec) begin
        pc <= pc_nx;
        if (op[3:2] != 2'b11) c <= sum[W];
        if (op[3:2] == 2'b00) a <= sum[W-1:0];
        if (op[3:2] == 2'b01) b <= sum[W-1:0];
        if (op[3:2] == 2'b10) out <= sum[W-1:0];
      end
    end
  end
  assign bus.regPC = pc;
  assign bus.regOUT = out;
  assign bus.out_valid = ov;
  assign bus.carry = c;
  assign bus.halted = state == HALT;
endmodule

// File: tb/tb_td4_core.sv
// tb_td4_core: directed vectors against hand-computed results for td4_core
module tb_td4_core;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  td4_core_if #(.W(4), .PC_W(4)) bus();
  td4_core #(.W(4), .PC_W(4)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] i);
    bus.instr = i;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.instr = 8'hD0;
    bus.regIN = 4'h0;
    bus.run = 1'b0;
    bus.resume = 1'b0;
    #1;
    check("rst_pc", bus.regPC, 0);
    check("rst_out", bus.regOUT, 0);
    check("rst_ov", bus.out_valid, 0);
    check("rst_c", bus.carry, 0);
    check("rst_halt", bus.halted, 0);
    #1 clr = 1'b1;
    bus.run = 1'b1;
    step(8'b0011_1110);
    check("ld_a_pc", bus.regPC, 1);
    step(8'b0000_0011);
    check("add_carry", bus.carry, 1);
    step(8'b1110_0101);
    check("jnc_taken_c1", bus.regPC, 3);
    step(8'b0000_0000);
    check("add_nocarry", bus.carry, 0);
    step(8'b1110_0101);
    check("jnc_jump", bus.regPC, 5);
    step(8'b0100_0000);
    step(8'b1000_0000);
    check("a_wrap_out", bus.regOUT, 1);
    check("a_wrap_ov", bus.out_valid, 1);
    check("pc7", bus.regPC, 7);
    step(8'b1100_0000);
    check("hlt_pc", bus.regPC, 8);
    check("hlt_halted", bus.halted, 1);
    check("hlt_ov", bus.out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      step(i[0] ? 8'b1111_0000 : 8'b1000_0011);
      check("halt_pc_hold", bus.regPC, 8);
      check("halt_ov", bus.out_valid, 0);
    end
    check("halt_out_hold", bus.regOUT, 1);
    bus.run = 1'b0;
    bus.resume = 1'b1;
    step(8'b1111_0000);
    check("resume_halted", bus.halted, 0);
    check("resume_no_exec", bus.regPC, 8);
    bus.resume = 1'b0;
    step(8'b1111_0000);
    check("resume_run0", bus.regPC, 8);
    bus.run = 1'b1;
    step(8'b1101_0000);
    check("resume_exec", bus.regPC, 9);
    step(8'b0111_0011);
    step(8'b1000_0010);
    check("out_b_im", bus.regOUT, 5);
    check("out_b_ov", bus.out_valid, 1);
    step(8'b1101_0000);
    check("nop_ov", bus.out_valid, 0);
    check("nop_out", bus.regOUT, 5);
    check("pc12", bus.regPC, 12);
    step(8'b0101_1111);
    check("b_carry", bus.carry, 1);
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(8'b0101_0001);
      check("stall_pc", bus.regPC, 13);
      check("stall_c", bus.carry, 1);
    end
    bus.run = 1'b1;
    step(8'b0101_0001);
    check("unstall_c", bus.carry, 0);
    step(8'b1000_0000);
    check("b_inc_once", bus.regOUT, 3);
    check("pc15", bus.regPC, 15);
    step(8'b1101_0000);
    check("pc_wrap", bus.regPC, 0);
    step(8'b0000_1111);
    check("c_set", bus.carry, 1);
    step(8'b1111_1010);
    check("jmp_pc", bus.regPC, 10);
    check("jmp_c", bus.carry, 1);
    step(8'b1110_0000);
    check("jnc_c1_fall", bus.regPC, 11);
    bus.regIN = 4'h9;
    step(8'b0110_0100);
    step(8'b1000_0000);
    check("in_add", bus.regOUT, 13);
    step(8'b1010_0110);
    check("out_im", bus.regOUT, 6);
    check("out_im_ov", bus.out_valid, 1);
    check("out_im_pc", bus.regPC, 14);
    step(8'b0011_0111);
    step(8'b0111_0011);
    step(8'b1000_0000);
    check("pre_rst_out", bus.regOUT, 3);
    step(8'b1100_0000);
    check("pre_rst_halt", bus.halted, 1);
    #2 clr = 1'b0;
    #1;
    check("arst_pc", bus.regPC, 0);
    check("arst_out", bus.regOUT, 0);
    check("arst_c", bus.carry, 0);
    check("arst_halt", bus.halted, 0);
    check("arst_ov", bus.out_valid, 0);
    #1 clr = 1'b1;
    step(8'b0100_0001);
    step(8'b1000_0000);
    check("arst_a", bus.regOUT, 1);
    check("arst_pc2", bus.regPC, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/td4_core.md
TD4_CORE -- requirements
Module: td4_core

Interface
REQ-001 Parameter W, default 4: data width of A, B, IN, OUT and the immediate.
REQ-002 Parameter PC_W, default 4: program counter width; program space 2^PC_W words.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 instr  input  4+W  instruction word from external ROM addressed by regPC: [W+3:W] opcode, [W-1:0] immediate Im.
REQ-006 regIN  input  W  input port, sampled combinationally during execute.
REQ-007 run  input  1  1 = execute one instruction per cycle; 0 = stall.
REQ-008 resume  input  1  leave HALT; ignored outside HALT.
REQ-009 regPC  output  PC_W  program counter, drives the ROM address.
REQ-010 regOUT  output  W  output port register.
REQ-011 out_valid  output  1  one-cycle pulse in the cycle after regOUT is written.
REQ-012 carry  output  1  registered carry flag C.
REQ-013 halted  output  1  1 while in HALT.

Function
REQ-014 The block SHALL have a two-state FSM: RUN and HALT.
REQ-015 Executed instruction: state RUN and run=1; one instruction per cycle, results visible the next cycle.
REQ-016 When not executing (run=0 or HALT), A, B, regOUT, C and regPC SHALL hold; out_valid SHALL be 0.
REQ-017 Adder: sum[W:0] = src + Im, zero-extended to W+1 bits; destination takes sum[W-1:0].
REQ-018 Opcodes: 0000 A<=A+Im; 0001 A<=B+Im; 0010 A<=IN+Im; 0011 A<=Im; 0100 B<=A+Im; 0101 B<=B+Im; 0110 B<=IN+Im; 0111 B<=Im; 1000/1001 OUT<=B+Im; 1010/1011 OUT<=Im.
REQ-019 Every executed opcode 0000-1011 SHALL load C with sum[W]; opcodes 11xx SHALL leave C unchanged.
REQ-020 1100 HLT: regPC<=regPC+1, state<=HALT.
REQ-021 1101 NOP: regPC<=regPC+1 only.
REQ-022 1110 JNC: regPC<=target if C=0, otherwise regPC+1; tests the registered C set by an earlier instruction.
REQ-023 1111 JMP: regPC<=target unconditionally.
REQ-024 target = Im truncated to PC_W bits if PC_W<=W, otherwise zero-extended.
REQ-025 All other executed opcodes: regPC<=regPC+1, wrapping modulo 2^PC_W.
REQ-026 out_valid SHALL be 1 for exactly the cycle after each executed opcode 10xx, even if regOUT does not change.
REQ-027 In HALT, instr SHALL be ignored; resume=1 SHALL return the FSM to RUN the next cycle without executing that cycle.
REQ-028 resume and run are independent: after resume, execution proceeds only when run=1.
REQ-029 halted SHALL equal (state==HALT), registered.

Reset
REQ-030 clr=0 SHALL immediately, independent of clk, set regPC=0, A=0, B=0, regOUT=0, C=0, out_valid=0, state=RUN, halted=0.
REQ-031 Reset SHALL take precedence mid-instruction and in HALT; the first instruction executes on the first rising edge with clr=1 and run=1.

Verification (W=4, PC_W=4)
REQ-032 clr pulsed low between edges with A=7, OUT=3, halted=1 -> all outputs 0 and halted=0 before the next edge.
REQ-033 A=0xE, instr 0000_0011 -> A=0x1, C=1; next instr 1110_0101 -> regPC=prev+1; then 0000_0000 (C=0) and 1110_0101 -> regPC=5.
REQ-034 B=3, instr 1000_0010 -> regOUT=5 and out_valid=1 for one cycle; the following NOP -> out_valid=0, regOUT=5.
REQ-035 HLT at regPC=7 -> regPC=8, halted=1, regPC holds 8 for 5 cycles regardless of instr; resume=1 -> halted=0, then execution resumes at address 8.
REQ-036 run=0 for 3 cycles with instr 0101_0001 -> B, C and regPC unchanged; run=1 -> B increments once.
REQ-037 regPC=15, NOP -> regPC=0; instr 1111_1010 -> regPC=10, C unchanged.
